// File: rtl/uart_pkg.sv
// Shared register map, status/control bit positions and FSM encoding for fifo_uart.
package uart_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_DIV_LO = 2'd2;
    localparam logic [1:0] ADDR_DIV_HI = 2'd3;

    localparam int unsigned ST_RX_NE      = 0;
    localparam int unsigned ST_TX_IDLE    = 1;
    localparam int unsigned ST_TX_FULL    = 2;
    localparam int unsigned ST_RX_FULL    = 3;
    localparam int unsigned ST_FRAME_ERR  = 4;
    localparam int unsigned ST_OVERRUN    = 5;
    localparam int unsigned ST_PARITY_ERR = 6;
    localparam int unsigned ST_IRQ        = 7;

    localparam int unsigned CTL_RX_IE    = 0;
    localparam int unsigned CTL_TX_IE    = 1;
    localparam int unsigned CTL_PAR_EN   = 2;
    localparam int unsigned CTL_PAR_ODD  = 3;
    localparam int unsigned CTL_RX_FLUSH = 4;
    localparam int unsigned CTL_TX_FLUSH = 5;
    localparam int unsigned CTL_LOOPBACK = 6;

    // Smallest usable divisor; lower values would leave no room for mid-bit sampling.
    localparam int unsigned MIN_DIV = 7;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a pop on a full FIFO frees room for a push in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fifo_uart.sv
// Register-mapped UART with RX/TX FIFOs, optional parity, loopback and sticky error flags.
// DIV_W is expected in the range 9..16 (divisor is split across two byte registers).
module fifo_uart
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 24_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ / BAUD - 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);

    logic wr_en, rd_en, ctl_wr, status_rd, data_rd, tx_push, rx_flush, tx_flush;
    assign wr_en     = cs & we;
    assign rd_en     = cs & ~we;
    assign ctl_wr    = wr_en && (addr == ADDR_STATUS);
    assign status_rd = rd_en && (addr == ADDR_STATUS);
    assign data_rd   = rd_en && (addr == ADDR_DATA);
    assign tx_push   = wr_en && (addr == ADDR_DATA);
    assign rx_flush  = ctl_wr & din[CTL_RX_FLUSH];
    assign tx_flush  = ctl_wr & din[CTL_TX_FLUSH];

    logic             rx_ie_q, tx_ie_q, par_en_q, par_odd_q, loopback_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic [15:0]      div_rd;
    assign div_eff = (div_q < DIV_MIN) ? DIV_MIN : div_q;
    assign div_rd  = 16'(div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            loopback_q <= 1'b0;
            div_q      <= DIV_RST;
        end else begin
            if (ctl_wr) begin
                rx_ie_q    <= din[CTL_RX_IE];
                tx_ie_q    <= din[CTL_TX_IE];
                par_en_q   <= din[CTL_PAR_EN];
                par_odd_q  <= din[CTL_PAR_ODD];
                loopback_q <= din[CTL_LOOPBACK];
            end
            if (wr_en && addr == ADDR_DIV_LO) div_q[7:0]       <= din;
            if (wr_en && addr == ADDR_DIV_HI) div_q[DIV_W-1:8] <= din[DIV_W-9:0];
        end
    end

    // FIFOs
    logic       tx_pop, tx_empty, tx_full;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0] rx_head;
    logic [7:0] rx_shift_q, rx_shift_d;

    assign rx_pop = data_rd & ~rx_empty;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (tx_flush),
        .push  (tx_push),
        .din   (din),
        .pop   (tx_pop),
        .head  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (rx_flush),
        .push  (rx_push),
        .din   (rx_shift_q),
        .pop   (rx_pop),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // Transmitter
    uart_state_e      tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_out_q, tx_out_d, tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
    logic             tx_bit_done, tx_start;

    assign tx_bit_done = (tx_cnt_q == tx_div_q);
    // Back-to-back frames: a new start bit follows the stop bit with no idle gap.
    assign tx_start = ~tx_empty &&
                      ((tx_state_q == StIdle) || (tx_state_q == StStop && tx_bit_done));

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + DIV_W'(1);
        tx_div_d    = tx_div_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_out_d    = tx_out_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        tx_pop      = 1'b0;
        unique case (tx_state_q)
            StIdle: tx_cnt_d = '0;
            StStart: if (tx_bit_done) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_out_d   = tx_shift_q[0];
                tx_state_d = StData;
            end
            StData: if (tx_bit_done) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_out_d   = tx_par_en_q ? tx_par_q : 1'b1;
                    tx_state_d = tx_par_en_q ? StParity : StStop;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_out_d   = tx_shift_q[1];
                end
            end
            StParity: if (tx_bit_done) begin
                tx_cnt_d   = '0;
                tx_out_d   = 1'b1;
                tx_state_d = StStop;
            end
            StStop: if (tx_bit_done) begin
                tx_cnt_d   = '0;
                tx_state_d = StIdle;
            end
            default: tx_state_d = StIdle;
        endcase
        if (tx_start) begin
            tx_pop      = 1'b1;
            tx_state_d  = StStart;
            tx_cnt_d    = '0;
            tx_div_d    = div_eff;
            tx_shift_d  = tx_head;
            tx_par_en_d = par_en_q;
            tx_par_d    = parity_bit(tx_head, par_odd_q);
            tx_out_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= StIdle;
            tx_cnt_q    <= '0;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_out_q    <= 1'b1;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_out_q    <= tx_out_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
        end
    end

    assign tx = loopback_q ? 1'b1 : tx_out_q;

    // Receiver
    logic             rx_src, rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e      rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_target;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic             rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic             rx_par_bad_q, rx_par_bad_d, rx_sample, set_fe, set_pe, set_oe;

    assign rx_src    = loopback_q ? tx_out_q : rx;
    // First sample lands mid start bit; every later one is a full bit period further on.
    assign rx_target = (rx_state_q == StStart) ? (rx_div_q >> 1) : rx_div_q;
    assign rx_sample = (rx_cnt_q == rx_target);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + DIV_W'(1);
        rx_div_d     = rx_div_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push      = 1'b0;
        set_fe       = 1'b0;
        set_pe       = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q & ~rx_sync_q) begin
                    rx_state_d   = StStart;
                    rx_div_d     = div_eff;
                    rx_par_en_d  = par_en_q;
                    rx_par_odd_d = par_odd_q;
                    rx_par_bad_d = 1'b0;
                end
            end
            StStart: if (rx_sample) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? StIdle : StData;
            end
            StData: if (rx_sample) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = rx_par_en_q ? StParity : StStop;
            end
            StParity: if (rx_sample) begin
                rx_cnt_d     = '0;
                rx_par_bad_d = rx_sync_q != parity_bit(rx_shift_q, rx_par_odd_q);
                rx_state_d   = StStop;
            end
            StStop: if (rx_sample) begin
                rx_cnt_d   = '0;
                rx_push    = 1'b1;
                set_fe     = ~rx_sync_q;
                set_pe     = rx_par_bad_q;
                rx_state_d = StIdle;
            end
            default: rx_state_d = StIdle;
        endcase
    end

    assign set_oe = rx_push & rx_full & ~rx_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= StIdle;
            rx_cnt_q     <= '0;
            rx_div_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bad_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx_src;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_div_q     <= rx_div_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_par_bad_q <= rx_par_bad_d;
        end
    end

    // Sticky errors: a status read clears them, but a new error in that cycle survives.
    logic fe_q, oe_q, pe_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_q <= 1'b0;
            oe_q <= 1'b0;
            pe_q <= 1'b0;
        end else begin
            fe_q <= (fe_q & ~status_rd) | set_fe;
            oe_q <= (oe_q & ~status_rd) | set_oe;
            pe_q <= (pe_q & ~status_rd) | set_pe;
        end
    end

    assign irq = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) | fe_q | oe_q | pe_q;

    logic [7:0] status;
    always_comb begin
        status                = '0;
        status[ST_RX_NE]      = ~rx_empty;
        status[ST_TX_IDLE]    = tx_empty && (tx_state_q == StIdle);
        status[ST_TX_FULL]    = tx_full;
        status[ST_RX_FULL]    = rx_full;
        status[ST_FRAME_ERR]  = fe_q;
        status[ST_OVERRUN]    = oe_q;
        status[ST_PARITY_ERR] = pe_q;
        status[ST_IRQ]        = irq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else if (rd_en) begin
            unique case (addr)
                ADDR_STATUS: dout <= status;
                ADDR_DATA:   dout <= rx_empty ? 8'h00 : rx_head;
                ADDR_DIV_LO: dout <= div_rd[7:0];
                ADDR_DIV_HI: dout <= div_rd[15:8];
            endcase
        end
    end

endmodule

// File: doc/fifo_uart.md
FIFO_UART -- requirements
Module: fifo_uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 24_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, reset-time bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries per RX and TX FIFO (power of two, >=2).
REQ-004 SHALL have parameter DIV_W, default 16, baud divisor width.
REQ-005 SHALL have port clk  in  1  system clock; the block has one clock.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port cs  in  1  chip select.
REQ-008 SHALL have port we  in  1  write enable.
REQ-009 SHALL have port addr  in  2  register select (0 status/control, 1 data, 2 divisor low, 3 divisor high).
REQ-010 SHALL have port din  in  8  write data.
REQ-011 SHALL have port dout  out  8  registered read data.
REQ-012 SHALL have port rx  in  1  serial input.
REQ-013 SHALL have port tx  out  1  serial output, idle high.
REQ-014 SHALL have port irq  out  1  high-true interrupt.

Function
REQ-015 SHALL load dout on the clk edge where cs&~we, holding it otherwise; read latency is 1 cycle.
REQ-016 SHALL return this status at addr 0: bit0 rx_not_empty, bit1 tx_idle (TX FIFO empty and shifter idle), bit2 tx_full, bit3 rx_full, bit4 framing_err, bit5 overrun, bit6 parity_err, bit7 irq.
REQ-017 SHALL decode control writes at addr 0: bit0 rx_ie, bit1 tx_ie, bit2 parity_en, bit3 parity_odd, bit4 rx_flush, bit5 tx_flush, bit6 loopback, bit7 reserved; flush bits are self-clearing single-cycle actions.
REQ-018 SHALL push din into the TX FIFO on a write to addr 1; a write while tx_full is dropped with no other effect.
REQ-019 SHALL pop the RX FIFO head into dout on a read of addr 1; a read while empty returns 0x00 and does not change state.
REQ-020 SHALL allow a simultaneous push and pop on either FIFO in one cycle, count unchanged; on a full RX FIFO the pop occurs first, so a push in the same cycle is accepted.
REQ-021 SHALL transmit frames as start(0), 8 data bits LSB first, optional parity bit, stop(1), via TX FSM states IDLE->START->DATA->PARITY (only if parity_en)->STOP->IDLE.
REQ-022 SHALL start a new frame the cycle after STOP completes when the TX FIFO is non-empty, with no idle gap.
REQ-023 SHALL use a bit period of divisor+1 clk cycles, where divisor = {div_hi, div_lo} and divisors below 7 are treated as 7.
REQ-024 SHALL latch the divisor for each frame at frame start; divisor writes never alter a frame in progress.
REQ-025 SHALL sync rx through two flops; the RX FSM has states IDLE->START->DATA->PARITY (if enabled)->STOP.
REQ-026 SHALL sample rx at mid-bit (divisor/2 after the falling edge); a start bit sampled high returns the FSM to IDLE with no error.
REQ-027 SHALL set framing_err on a stop bit sampled low, and parity_err on a parity mismatch; the byte is still pushed.
REQ-028 SHALL discard a received byte arriving while the RX FIFO is full and set overrun.
REQ-029 SHALL hold framing_err, parity_err and overrun sticky, clearing them on a status read; a set in the same cycle as the clear wins.
REQ-030 SHALL, when loopback=1, drive the RX input from the internal tx and hold the tx pin high.
REQ-031 SHALL drive irq = (rx_ie & rx_not_empty) | (tx_ie & tx FIFO empty) | any sticky error, combinationally from registered state.
REQ-032 SHALL, on rx_flush/tx_flush, empty the respective FIFO; tx_flush does not abort the frame in progress.

Reset
REQ-033 SHALL, asynchronously while rst_n=0, set dout=0x00, tx=1, both FSMs IDLE, both FIFOs empty, and all control bits and sticky flags 0.
REQ-034 SHALL reset the divisor to CLK_FREQ/BAUD-1 (207 at default parameters); irq=0 after reset.
REQ-035 SHALL, if reset is asserted mid-frame, immediately return tx high and lose the partial frame.

Structure
REQ-036 SHALL place register addresses, status/control bit indices, and FSM state encodings in shared package uart_pkg.
REQ-037 SHALL implement each FIFO as one instance of sub-module sync_fifo (parameter DEPTH, WIDTH), instantiated for RX (WIDTH 8) and TX (WIDTH 8).

Verification
REQ-038 SHALL cover: write 0x55 to addr 1 at default parameters -> tx shows 0,1,0,1,0,1,0,1,0,1 with each bit 208 clk.
REQ-039 SHALL cover: with loopback, write 0xA3 -> rx_not_empty within 10 bit periods, and a data read returns 0xA3 with rx_not_empty then 0.
REQ-040 SHALL cover: 17 received bytes with no reads at FIFO_DEPTH=16 -> rx_full=1, overrun=1, and the first 16 bytes read back intact in order.
REQ-041 SHALL cover: a received frame with stop=0 -> framing_err=1 and irq=1; a status read then clears the flag.
REQ-042 SHALL cover: parity_en=1, parity_odd=1, transmit 0x01 -> parity bit 0; receiving a wrong parity -> parity_err=1.
REQ-043 SHALL cover: rst_n pulsed low mid-frame -> tx=1 in the same cycle, divisor reads 207, and the FIFOs are empty.
